correlator_readout: RTL

Integration-window controller and histogram readout stage directly downstream of the intensity correlator. It times fixed-length integration windows, snapshots the correlator's flat bin bus at each window end, and clears the correlator for the next window. It then streams the snapshot out one bin per beat over a valid/ready interface while the next window integrates.

---
 rtl/correlator_pkg.sv | 24 ++
 rtl/correlator_readout_if.sv | 28 ++
 rtl/correlator_readout_stream.sv | 85 ++++++++
 rtl/correlator_readout.sv | 107 ++++++++++
 4 files changed

// File: rtl/correlator_pkg.sv
// Shared types and widths for the correlator readout stage.
package correlator_pkg;

  localparam int FRAME_W = 16;
  localparam int OVR_W   = 8;

  typedef enum logic [1:0] {
    IDLE,
    INTEGRATE,
    CAPTURE,
    CLEAR
  } win_state_t;

  typedef enum logic {
    S_IDLE,
    S_SEND
  } stream_state_t;

  // Bin index width; a single-bin histogram still needs a 1-bit index.
  function automatic int bin_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/correlator_readout_if.sv
// Valid/ready beat interface carrying one histogram bin per beat.
interface correlator_readout_if #(
  parameter int NUM_BINS   = 501,
  parameter int RESOLUTION = 32
);
  import correlator_pkg::*;

  localparam int BIN_W = bin_width(NUM_BINS);

  logic [RESOLUTION-1:0] m_data;
  logic [BIN_W-1:0]      m_bin;
  logic                  m_first;
  logic                  m_last;
  logic [FRAME_W-1:0]    m_frame;
  logic                  m_valid;
  logic                  m_ready;

  modport master (
    output m_data, m_bin, m_first, m_last, m_frame, m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data, m_bin, m_first, m_last, m_frame, m_valid,
    output m_ready
  );

endinterface

// File: rtl/correlator_readout_stream.sv
// Snapshot bank, bin mux, valid/ready handshake and overrun counter.
module correlator_readout_stream
  import correlator_pkg::*;
#(
  parameter int NUM_BINS   = 501,
  parameter int RESOLUTION = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           capture,
  input  logic [RESOLUTION*NUM_BINS-1:0] hist_q,
  correlator_readout_if.master           m,
  output logic [OVR_W-1:0]               overrun_count
);

  localparam int BIN_W = bin_width(NUM_BINS);
  localparam logic [BIN_W-1:0] LAST_BIN = BIN_W'(NUM_BINS - 1);

  logic [RESOLUTION-1:0] hist_bins [NUM_BINS];
  logic [RESOLUTION-1:0] snap_reg  [NUM_BINS];
  stream_state_t         state_reg;
  logic [FRAME_W-1:0]    frame_cnt_reg;
  logic [BIN_W-1:0]      bin_next;
  logic                  accept;
  logic                  last_accept;
  logic                  load;

  genvar gi;
  generate
    for (gi = 0; gi < NUM_BINS; gi++) begin : g_unpack
      assign hist_bins[gi] = hist_q[gi*RESOLUTION +: RESOLUTION];
    end
  endgenerate

  assign accept      = m.m_valid && m.m_ready;
  assign last_accept = accept && m.m_last;
  assign bin_next    = m.m_bin + 1'b1;
  // A new frame is taken when idle, or when the old frame finishes this very cycle.
  assign load        = capture && ((state_reg == S_IDLE) || last_accept);

  // Snapshot bank: reloaded only when a capture is accepted as a new frame.
  always_ff @(posedge clk) begin
    if (load) snap_reg <= hist_bins;
  end

  // Beat sequencing, frame numbering and dropped-frame accounting.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= S_IDLE;
      m.m_valid     <= 1'b0;
      m.m_data      <= '0;
      m.m_bin       <= '0;
      m.m_first     <= 1'b0;
      m.m_last      <= 1'b0;
      m.m_frame     <= '0;
      frame_cnt_reg <= '0;
      overrun_count <= '0;
    end else begin
      if (load) begin
        state_reg     <= S_SEND;
        m.m_valid     <= 1'b1;
        m.m_data      <= hist_bins[0];
        m.m_bin       <= '0;
        m.m_first     <= 1'b1;
        m.m_last      <= (NUM_BINS == 1);
        m.m_frame     <= frame_cnt_reg;
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end else if (last_accept) begin
        state_reg <= S_IDLE;
        m.m_valid <= 1'b0;
        m.m_first <= 1'b0;
        m.m_last  <= 1'b0;
      end else if (accept) begin
        m.m_data  <= snap_reg[bin_next];
        m.m_bin   <= bin_next;
        m.m_first <= 1'b0;
        m.m_last  <= (bin_next == LAST_BIN);
      end
      if (capture && !load && (overrun_count != '1)) begin
        overrun_count <= overrun_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/correlator_readout.sv
// Integration-window controller: times windows, clears the correlator and
// hands each window's snapshot to the stream engine.
module correlator_readout
  import correlator_pkg::*;
#(
  parameter int NUM_BINS     = 501,
  parameter int RESOLUTION   = 32,
  parameter int CLEAR_CYCLES = 2
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           enable,
  input  logic [31:0]                    integ_len,
  input  logic [RESOLUTION*NUM_BINS-1:0] hist_in,
  output logic                           corr_reset,
  correlator_readout_if.master           m,
  output logic [OVR_W-1:0]               overrun_count,
  output logic                           busy
);

  win_state_t                     state_reg;
  logic [31:0]                    timer_reg;
  logic [15:0]                    clr_cnt_reg;
  logic                           final_reg;
  logic                           capture_reg;
  logic [RESOLUTION*NUM_BINS-1:0] hist_q;

  // Input stage: the snapshot always sees the bus as it was one cycle earlier.
  always_ff @(posedge clk) begin
    hist_q <= hist_in;
  end

  // Window FSM with registered corr_reset, busy and capture strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg   <= IDLE;
      timer_reg   <= '0;
      clr_cnt_reg <= '0;
      final_reg   <= 1'b0;
      capture_reg <= 1'b0;
      corr_reset  <= 1'b1;
      busy        <= 1'b0;
    end else begin
      capture_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (enable) begin
            state_reg   <= CLEAR;
            clr_cnt_reg <= '0;
            final_reg   <= 1'b0;
            busy        <= 1'b1;
            corr_reset  <= 1'b1;
          end
        end
        CLEAR: begin
          if (clr_cnt_reg == 16'(CLEAR_CYCLES - 1)) begin
            if (final_reg) begin
              state_reg  <= IDLE;
              busy       <= 1'b0;
              corr_reset <= 1'b1;
            end else begin
              state_reg  <= INTEGRATE;
              timer_reg  <= (integ_len == 32'd0) ? 32'd1 : integ_len;
              corr_reset <= 1'b0;
            end
          end else begin
            clr_cnt_reg <= clr_cnt_reg + 1'b1;
          end
        end
        INTEGRATE: begin
          if (timer_reg <= 32'd1) begin
            state_reg   <= CAPTURE;
            capture_reg <= 1'b1;
          end else begin
            timer_reg <= timer_reg - 1'b1;
          end
        end
        CAPTURE: begin
          // The correlator is always cleared after a window; without enable
          // this clear pass is the last one before going idle.
          state_reg   <= CLEAR;
          clr_cnt_reg <= '0;
          final_reg   <= !enable;
          corr_reset  <= 1'b1;
        end
        default: begin
          state_reg  <= IDLE;
          corr_reset <= 1'b1;
          busy       <= 1'b0;
        end
      endcase
    end
  end

  correlator_readout_stream #(
    .NUM_BINS   (NUM_BINS),
    .RESOLUTION (RESOLUTION)
  ) u_stream (
    .clk           (clk),
    .reset         (reset),
    .capture       (capture_reg),
    .hist_q        (hist_q),
    .m             (m),
    .overrun_count (overrun_count)
  );

endmodule
